// File: rtl/irq_pending_8.sv
// irq_pending_8: rising-edge capture of eight request lines into sticky pending bits, masked
// output to the downstream OR reduction, and lowest-index valid/ack presentation.
// Define IRQ_SYNC_EN to insert a two-flop synchronizer on each req_in line.
module irq_pending_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       clr_we,
    input  logic [7:0] clr_wdata,
    input  logic       ack,
    output logic [7:0] pending_out,
    output logic [7:0] mask_q,
    output logic       irq_valid,
    output logic [2:0] irq_id
);

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] req_s;
    logic [7:0] req_d;
    logic [7:0] edge_det;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] clr_vec;
    logic [7:0] ack_vec;
    logic [2:0] irq_id_q;
    logic [2:0] irq_id_d;
    logic [2:0] low_idx;
    logic       ack_take;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= req_in;
            sync2 <= sync1;
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req_in;
`endif

    assign edge_det = req_s & ~req_d;

    // Only an ack seen while presenting may clear a bit; edges are OR-ed in last so a set wins.
    assign ack_take  = (state_q == ST_PRESENT) && ack;
    assign ack_vec   = ack_take ? (8'd1 << irq_id_q) : '0;
    assign clr_vec   = clr_we ? clr_wdata : '0;
    assign pending_d = (pending_q & ~clr_vec & ~ack_vec) | edge_det;

    assign pending_out = pending_q & mask_q;
    assign irq_valid   = (state_q == ST_PRESENT);
    assign irq_id      = irq_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            req_d     <= req_s;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending_out[3'(7 - i)]) begin
                low_idx = 3'(7 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_out) begin
                    state_d  = ST_PRESENT;
                    irq_id_d = low_idx;
                end
            end
            ST_PRESENT: begin
                if (ack || !pending_out[irq_id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
